// File: rtl/i2c_regmap_pkg.sv
// Shared write-FSM state type and pointer-advance helper for i2c_regmap_ctrl.
// Build option: define I2C_REGMAP_AUTOINC_EN for burst (auto-increment) pointer behaviour.
package i2c_regmap_pkg;

  typedef enum logic {
    ST_PTR  = 1'b0,
    ST_DATA = 1'b1
  } wr_state_e;

  // Widest pointer supported (128 registers); callers slice down to their PW.
  localparam int unsigned PTR_MAX_W = 7;

  function automatic logic [PTR_MAX_W-1:0] ptr_next(input logic [PTR_MAX_W-1:0] ptr,
                                                     input int unsigned num_regs);
    logic [PTR_MAX_W-1:0] mask;
    mask = PTR_MAX_W'(num_regs - 1);
`ifdef I2C_REGMAP_AUTOINC_EN
    return (ptr + 1'b1) & mask;
`else
    return ptr & mask;
`endif
  endfunction

endpackage

// File: rtl/i2c_regmap_file.sv
// NUM_REGS x 8 register storage with one write port, an RO-aware read mux and
// a flattened view of the contents.
module i2c_regmap_file
  import i2c_regmap_pkg::*;
#(
  parameter int unsigned          NUM_REGS  = 16,
  parameter int unsigned          PW        = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0]  RO_MASK   = 16'hF000,
  parameter logic [7:0]           RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [PW-1:0]         waddr,
  input  logic [7:0]            wdata,
  input  logic [PW-1:0]         raddr,
  input  logic [8*NUM_REGS-1:0] status_in,
  output logic [7:0]            rd_data,
  output logic [8*NUM_REGS-1:0] regs_out
);

  logic [7:0] mem_q [NUM_REGS];
  logic [7:0] mem_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) mem_d[i] = mem_q[i];
    // Read-only slots are never written, so they keep RESET_VAL in the file.
    if (we && !RO_MASK[waddr]) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) mem_q[i] <= RESET_VAL;
      else     mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    rd_data = RO_MASK[raddr] ? status_in[{raddr, 3'b000} +: 8] : mem_q[raddr];
    for (int i = 0; i < NUM_REGS; i++) regs_out[8*i +: 8] = mem_q[i];
  end

endmodule

// File: rtl/i2c_regmap_ctrl.sv
// Register-map controller between the I2C slave byte streams and the chip.
// Build option: I2C_REGMAP_AUTOINC_EN enables pointer auto-increment (burst access).
module i2c_regmap_ctrl
  import i2c_regmap_pkg::*;
#(
  parameter int unsigned          NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = 16'hF000,
  parameter logic [7:0]           RESET_VAL = 8'h00,
  localparam int unsigned         PW        = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_tdata,
  input  logic                  rx_tvalid,
  output logic                  rx_tready,
  input  logic                  rx_tlast,
  output logic [7:0]            tx_tdata,
  output logic                  tx_tvalid,
  input  logic                  tx_tready,
  output logic                  tx_tlast,
  input  logic [8*NUM_REGS-1:0] status_in,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  wr_pulse,
  output logic [PW-1:0]         wr_addr,
  output logic [7:0]            wr_data
);

  wr_state_e            state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 rx_tready_q;
  logic                 refill_q, refill_d;
  logic                 tx_tvalid_q, tx_tvalid_d;
  logic [7:0]           tx_tdata_q, tx_tdata_d;
  logic                 wr_pulse_q, wr_pulse_d;
  logic [PW-1:0]        wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 rx_fire, tx_fire, wr_en;
  logic [PTR_MAX_W-1:0] ptr_ext, ptr_adv_ext;
  logic [7:0]           rd_data;

  i2c_regmap_file #(
    .NUM_REGS (NUM_REGS),
    .PW       (PW),
    .RO_MASK  (RO_MASK),
    .RESET_VAL(RESET_VAL)
  ) u_file (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_en),
    .waddr    (ptr_q),
    .wdata    (rx_tdata),
    .raddr    (ptr_q),
    .status_in(status_in),
    .rd_data  (rd_data),
    .regs_out (regs_out)
  );

  always_comb begin
    rx_fire     = rx_tvalid && rx_tready_q;
    tx_fire     = tx_tvalid_q && tx_tready;
    ptr_ext     = '0;
    ptr_ext[PW-1:0] = ptr_q;
    ptr_adv_ext = ptr_next(ptr_ext, NUM_REGS);

    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_en      = 1'b0;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    // An accepted rx byte owns the pointer; a same-cycle tx advance is dropped.
    if (rx_fire) begin
      if (state_q == ST_PTR) begin
        ptr_d   = rx_tdata[PW-1:0];
        state_d = rx_tlast ? ST_PTR : ST_DATA;
      end else begin
        wr_en      = !RO_MASK[ptr_q];
        wr_pulse_d = wr_en;
        if (wr_en) begin
          wr_addr_d = ptr_q;
          wr_data_d = rx_tdata;
        end
        ptr_d = ptr_adv_ext[PW-1:0];
        if (rx_tlast) state_d = ST_PTR;
      end
    end else if (tx_fire) begin
      ptr_d = ptr_adv_ext[PW-1:0];
    end

    // The first cycle out of reset counts as a refill so reg 0 gets prefetched.
    refill_d    = rx_fire || tx_fire || !rx_tready_q;
    tx_tvalid_d = tx_tvalid_q;
    tx_tdata_d  = tx_tdata_q;
    if (refill_d) begin
      tx_tvalid_d = 1'b0;
    end else if (refill_q) begin
      tx_tvalid_d = 1'b1;
      tx_tdata_d  = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PTR;
      ptr_q       <= '0;
      rx_tready_q <= 1'b0;
      refill_q    <= 1'b0;
      tx_tvalid_q <= 1'b0;
      tx_tdata_q  <= '0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rx_tready_q <= 1'b1;
      refill_q    <= refill_d;
      tx_tvalid_q <= tx_tvalid_d;
      tx_tdata_q  <= tx_tdata_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign rx_tready = rx_tready_q;
  assign tx_tvalid = tx_tvalid_q;
  assign tx_tdata  = tx_tdata_q;
  assign tx_tlast  = 1'b0;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
